// File: rtl/synth_pkg.sv
// synth_pkg: constants shared across the keyboard tone path.
//   - Note identifiers carried on note_id buses.
//   - Default half-period dividers (clk cycles at 25 MHz), the same values
//     the keyboard tone generator uses, so generator and decoder agree.
//   - State encoding for the note decoder FSM.
package synth_pkg;

  localparam logic [2:0] NOTE_SIL = 3'd0;
  localparam logic [2:0] NOTE_DO  = 3'd1;
  localparam logic [2:0] NOTE_RE  = 3'd2;
  localparam logic [2:0] NOTE_MI  = 3'd3;
  localparam logic [2:0] NOTE_FA  = 3'd4;
  localparam logic [2:0] NOTE_UNK = 3'd7;

  localparam int DIV_DO_DEF = 23860;
  localparam int DIV_RE_DEF = 21302;
  localparam int DIV_MI_DEF = 18977;
  localparam int DIV_FA_DEF = 17906;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: brings an asynchronous square wave into the clk domain.
// Two-flop synchronizer followed by a delay flop for edge detection.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous input
//   level out  synchronized level
//   rise  out  one-cycle pulse on the first synchronized high cycle
//   fall  out  one-cycle pulse on the first synchronized low cycle
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       meta_reg;
  logic       sync_reg;
  logic       dly_reg;
  logic [2:0] warm_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      dly_reg  <= 1'b0;
      warm_reg <= 3'b000;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      dly_reg  <= sync_reg;
      warm_reg <= {warm_reg[1:0], 1'b1};
    end
  end

  // The pipeline is cleared by reset, so a high input would otherwise show
  // up as a fake rise while the flops refill. Edges are only reported once
  // both sync_reg and dly_reg hold real samples of din.
  assign level = sync_reg;
  assign rise  = warm_reg[2] &  sync_reg & ~dly_reg;
  assign fall  = warm_reg[2] & ~sync_reg &  dly_reg;

endmodule

// File: rtl/pwm_note_decoder.sv
// pwm_note_decoder: measures high/low durations of a square-wave tone and
// classifies it as DO/RE/MI/FA, unknown (7) or silence (0).
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   pwm_in       in   tone input, may be asynchronous to clk
//   high_cnt     out  last completed high duration (clk cycles)
//   low_cnt      out  last completed low duration (clk cycles)
//   meas_valid   out  one-cycle pulse when high_cnt/low_cnt update
//   note_id      out  confirmed note id
//   note_change  out  one-cycle pulse when note_id changes
module pwm_note_decoder
  import synth_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int CNT_W   = 16,
  parameter int DIV_DO  = DIV_DO_DEF,
  parameter int DIV_RE  = DIV_RE_DEF,
  parameter int DIV_MI  = DIV_MI_DEF,
  parameter int DIV_FA  = DIV_FA_DEF,
  parameter int TOL     = 8,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic [2:0]       note_id,
  output logic             note_change
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int CAND_W = $clog2(CONFIRM + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [CAND_W-1:0] CAND_ONE  = CAND_W'(1);
  localparam logic [CAND_W-1:0] CAND_FULL = CAND_W'(CONFIRM);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Silence detection must not fire inside a legitimate half-period.
  if (TIMEOUT <= DIV_DO + TOL || TIMEOUT <= DIV_RE + TOL ||
      TIMEOUT <= DIV_MI + TOL || TIMEOUT <= DIV_FA + TOL ||
      CONFIRM < 1 || CLK_HZ < 1) begin : g_bad_cfg
    $error("pwm_note_decoder: invalid parameter set");
  end

  // Distance computed one bit wider than the counters so no wrap occurs.
  function automatic logic near(input logic [CNT_W-1:0] v, input int div);
    logic [CNT_W:0] a;
    logic [CNT_W:0] b;
    logic [CNT_W:0] d;
    a = {1'b0, v};
    b = (CNT_W + 1)'(div);
    d = (a >= b) ? a - b : b - a;
    return d <= (CNT_W + 1)'(TOL);
  endfunction

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] h,
                                          input logic [CNT_W-1:0] l);
    if (&h || &l)                            return NOTE_UNK;
    if (near(h, DIV_DO) && near(l, DIV_DO))  return NOTE_DO;
    if (near(h, DIV_RE) && near(l, DIV_RE))  return NOTE_RE;
    if (near(h, DIV_MI) && near(l, DIV_MI))  return NOTE_MI;
    if (near(h, DIV_FA) && near(l, DIV_FA))  return NOTE_FA;
    return NOTE_UNK;
  endfunction

  logic level;
  logic rise;
  logic fall;

  pwm_edge_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  dec_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  hcnt_reg, hcnt_next;
  logic [CNT_W-1:0]  lcnt_reg, lcnt_next;
  logic [CNT_W-1:0]  high_cnt_reg, high_cnt_next;
  logic [CNT_W-1:0]  low_cnt_reg, low_cnt_next;
  logic              meas_valid_reg, meas_valid_next;
  logic [2:0]        note_id_reg, note_id_next;
  logic              note_change_reg, note_change_next;
  logic [2:0]        cand_reg, cand_next;
  logic [CAND_W-1:0] cand_cnt_reg, cand_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [2:0]        cls;
  logic              timeout;

  always_comb begin
    state_next       = state_reg;
    hcnt_next        = hcnt_reg;
    lcnt_next        = lcnt_reg;
    high_cnt_next    = high_cnt_reg;
    low_cnt_next     = low_cnt_reg;
    meas_valid_next  = 1'b0;
    note_id_next     = note_id_reg;
    note_change_next = 1'b0;
    cand_next        = cand_reg;
    cand_cnt_next    = cand_cnt_reg;
    idle_cnt_next    = idle_cnt_reg;
    cls              = classify(hcnt_reg, lcnt_reg);

    // Saturating at TIMEOUT makes the timeout fire once per silent stretch;
    // any edge in the same cycle takes precedence.
    timeout = !(rise || fall) && (idle_cnt_reg == IDLE_LAST);
    if (rise || fall)
      idle_cnt_next = '0;
    else if (idle_cnt_reg != IDLE_MAX)
      idle_cnt_next = idle_cnt_reg + 1'b1;

    unique case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_HIGH;
          hcnt_next  = CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_next = ST_LOW;
          lcnt_next  = CNT_ONE;
        end else if (level && hcnt_reg != CNT_MAX) begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          high_cnt_next   = hcnt_reg;
          low_cnt_next    = lcnt_reg;
          meas_valid_next = 1'b1;
          state_next      = ST_HIGH;
          hcnt_next       = CNT_ONE;
          if (cls == cand_reg) begin
            if (cand_cnt_reg != CAND_FULL)
              cand_cnt_next = cand_cnt_reg + 1'b1;
          end else begin
            cand_next     = cls;
            cand_cnt_next = CAND_ONE;
          end
          if (cand_cnt_next == CAND_FULL && cls != note_id_reg) begin
            note_id_next     = cls;
            note_change_next = 1'b1;
          end
        end else if (!level && lcnt_reg != CNT_MAX) begin
          lcnt_next = lcnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (timeout) begin
      state_next    = ST_IDLE;
      cand_cnt_next = '0;
      if (note_id_reg != NOTE_SIL) begin
        note_id_next     = NOTE_SIL;
        note_change_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      hcnt_reg        <= '0;
      lcnt_reg        <= '0;
      high_cnt_reg    <= '0;
      low_cnt_reg     <= '0;
      meas_valid_reg  <= 1'b0;
      note_id_reg     <= NOTE_SIL;
      note_change_reg <= 1'b0;
      cand_reg        <= NOTE_SIL;
      cand_cnt_reg    <= '0;
      idle_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      hcnt_reg        <= hcnt_next;
      lcnt_reg        <= lcnt_next;
      high_cnt_reg    <= high_cnt_next;
      low_cnt_reg     <= low_cnt_next;
      meas_valid_reg  <= meas_valid_next;
      note_id_reg     <= note_id_next;
      note_change_reg <= note_change_next;
      cand_reg        <= cand_next;
      cand_cnt_reg    <= cand_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
    end
  end

  assign high_cnt    = high_cnt_reg;
  assign low_cnt     = low_cnt_reg;
  assign meas_valid  = meas_valid_reg;
  assign note_id     = note_id_reg;
  assign note_change = note_change_reg;

endmodule

// File: doc/pwm_note_decoder.md
# pwm_note_decoder

Measurement end of the keyboard tone path: samples a square-wave tone (the `pwm_out` of the keyboard tone generator, or an external pin), measures high and low durations in `clk` cycles, and classifies the tone as DO/RE/MI/FA, unknown, or silence. It sits after the tone generator for on-chip self-check, tuning display and loopback verification. `note_id` changes only after `CONFIRM` consecutive identical classifications.

## Interface
- `CLK_HZ`, 25_000_000, clock frequency; informational, not used in the datapath.
- `CNT_W`, 16, width of the high/low counters; counters saturate at 2^CNT_W-1.
- `DIV_DO` / `DIV_RE` / `DIV_MI` / `DIV_FA`, 23860 / 21302 / 18977 / 17906, expected half-period in cycles for each note.
- `TOL`, 8, allowed absolute deviation per half-period, in cycles.
- `CONFIRM`, 2, consecutive identical classifications required before `note_id` updates (≥1).
- `TIMEOUT`, 50000, cycles without any input edge before silence is declared; must be greater than the largest DIV + TOL.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  tone input; may be asynchronous to `clk`.
- `high_cnt`  out  CNT_W  last completed high duration.
- `low_cnt`  out  CNT_W  last completed low duration.
- `meas_valid`  out  1  one-cycle pulse when `high_cnt`/`low_cnt` update.
- `note_id`  out  3  confirmed note: 0 silence, 1 DO, 2 RE, 3 MI, 4 FA, 7 unknown.
- `note_change`  out  1  one-cycle pulse when `note_id` changes value.

## Operation
- Input path: 2-flop synchronizer, then a delay flop for edge detect (`rise`, `fall`).
- FSM states:
  - IDLE: wait for `rise`, discarding any partial period; on `rise`, go to HIGH with `hcnt=1`.
  - HIGH: `hcnt++` per cycle; on `fall`, go to LOW with `lcnt=1`.
  - LOW: `lcnt++` per cycle; on `rise`:
    - latch `high_cnt`/`low_cnt`;
    - pulse `meas_valid`;
    - classify;
    - go to HIGH with `hcnt=1`.
- Counts equal the number of clocks the synchronized level was high or low. An ideal source of half-period N yields exactly N/N.
- Classification:
  - A note matches if |hcnt-DIV| ≤ TOL and |lcnt-DIV| ≤ TOL.
  - Priority when matches overlap: DO > RE > MI > FA.
  - No match, or either count saturated → 7.
  - Comparisons are unsigned, CNT_W+1 bits wide; no wrap-around.
- Confirmation:
  - `cand` and `cand_cnt` track the run of identical classifications.
  - A different class resets `cand_cnt` to 1.
  - When `cand_cnt` reaches CONFIRM and `cand != note_id`: `note_id <= cand` and pulse `note_change`.
- Timeout:
  - An `idle_cnt` counter is cleared on every `rise`/`fall` and increments otherwise.
  - On reaching TIMEOUT, in any state: go to IDLE, clear `cand_cnt`; if `note_id != 0`, set `note_id=0` and pulse `note_change`.
  - `high_cnt`/`low_cnt` keep their last values.
- Saturation: counters hold at all-ones, and the FSM keeps running until an edge or timeout occurs.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchronizer and edge flops 0, `cand`=0, `cand_cnt`=0, `idle_cnt`=0.
- Latency:
  - t = first `clk` edge that samples `pwm_in` high.
  - `meas_valid` and `high_cnt`/`low_cnt` are updated on edge t+2.
  - `note_id`/`note_change` update on the same edge (single registered stage).
- Minimum decode time: CONFIRM full periods plus the leading partial period.
- Simultaneous events:
  - `rise` and timeout in the same cycle → the edge wins, and `idle_cnt` clears.
  - `note_change` and `meas_valid` may coincide.
- Glitch: a high pulse of 1 cycle is measured as `hcnt=1` and classifies 7. No digital filtering is applied; the debouncing belongs upstream.
- `rst` mid-period: everything returns to reset values on the next edge. The first measurement after reset is discarded through IDLE.

## Structure
- Shared package `synth_pkg`:
  - note ID constants (`NOTE_SIL`=0 … `NOTE_FA`=4, `NOTE_UNK`=7);
  - default DIV_* values, shared with the keyboard tone generator.
- Sub-module `pwm_edge_sync`: 2-flop synchronizer plus delay flop, with outputs `level`, `rise`, `fall`.
- Top level contains the FSM, counters, classifier, confirmation logic and timeout.

## Test plan
- Reset, then ideal square wave with half-period 23860 → first `meas_valid` reports `high_cnt`=23860, `low_cnt`=23860; after the 2nd full period, `note_id`=1 with one `note_change` pulse.
- Switch from DO to MI (18977) → one `meas_valid` reporting 18977/18977 with `note_id` still 1; on the next period `note_id`=3.
- Half-periods 21302+8 and 21302-8 → `note_id`=2; half-periods 21302+9 → 7.
- Hold `pwm_in` low for 50000 cycles after FA → `note_id`=0, one `note_change`, FSM in IDLE; holding longer produces no further pulses.
- Asymmetric wave (high 17906, low 23860) → `note_id`=7; one-cycle glitch inside DO → `meas_valid` with `high_cnt`=1, and `note_id` unchanged until 2 consecutive 7s.
- Assert `rst` mid-HIGH → all outputs 0 next cycle; the partial period after reset produces no `meas_valid`.
